// File: rtl/breathe_seq.sv
// breathe_seq: multi-channel LED breathing sequencer.
// Each channel gets a triangle-wave brightness ramp rendered as PWM. A slot
// sequencer either breathes one channel per slot (with an optional all-off
// slot) or breathes all channels together.
// Optional feature macro: BREATHE_SEQ_GAMMA_EN selects a square-law
// brightness curve; when undefined the duty follows the level linearly.
//
// Ramp direction FSM:
//   state    | meaning
//   DIR_UP   | level rises one step per tick until it reaches LMAX
//   DIR_DOWN | level falls one step per tick; reaching 0 ends the breath

module breathe_seq #(
    parameter int NUM_CH         = 3,
    parameter int PWM_BITS       = 8,
    parameter int STEP_DIV       = 256,
    parameter int BREATHS_PER_CH = 1,
    parameter int OFF_SLOT       = 1,
    localparam int AW            = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              mode,
    output logic [NUM_CH-1:0] led_n,
    output logic [AW-1:0]     active_ch,
    output logic              breath_done
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]       PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LMAX      = '1;
    localparam logic [PWM_BITS-1:0] LMAX_M1   = LMAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [AW-1:0]       LAST_SLOT = AW'(NUM_CH - 1 + OFF_SLOT);
    localparam logic [7:0]          CNT_LAST  = 8'(BREATHS_PER_CH - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PW-1:0]       presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    logic [7:0]          breath_cnt;
    logic                mode_q;
    dir_t                dir;
    logic                tick;
    logic                breath_end;
    logic [NUM_CH-1:0]   sel;

    assign tick       = en && (presc == PRE_LAST);
    assign breath_end = tick && (dir == DIR_DOWN) && (level == LVL_ONE);

    // Step prescaler and free-running PWM counter; both freeze while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (en) begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Ramp FSM, breath counting, mode sampling and slot advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level       <= '0;
            dir         <= DIR_UP;
            breath_cnt  <= '0;
            active_ch   <= '0;
            mode_q      <= 1'b0;
            breath_done <= 1'b0;
        end else begin
            breath_done <= breath_end;
            if (tick) begin
                case (dir)
                    DIR_UP: begin
                        level <= level + 1'b1;
                        if (level == LMAX_M1)
                            dir <= DIR_DOWN;
                    end
                    DIR_DOWN: begin
                        level <= level - 1'b1;
                        if (level == LVL_ONE)
                            dir <= DIR_UP;
                    end
                    default: dir <= DIR_UP;
                endcase
            end
            if (breath_end) begin
                mode_q <= mode;
                if (mode) begin
                    // Unison: the slot pointer parks at 0 and stops advancing.
                    breath_cnt <= '0;
                    active_ch  <= '0;
                end else if (breath_cnt == CNT_LAST) begin
                    breath_cnt <= '0;
                    active_ch  <= (active_ch == LAST_SLOT) ? '0 : active_ch + 1'b1;
                end else begin
                    breath_cnt <= breath_cnt + 1'b1;
                end
            end
        end
    end

    // Duty register: one cycle behind the level in both curve variants.
`ifdef BREATHE_SEQ_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            duty <= '0;
        else if (en)
            duty <= PWM_BITS'(level_sq >> PWM_BITS);
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            duty <= '0;
        else if (en)
            duty <= level;
    end
`endif

    // Channel select: every channel in unison, otherwise only active_ch.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            sel[i] = mode_q | (active_ch == AW'(i));
    end

    // Registered active-low LED drive; forced dark while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_n <= '1;
        end else if (!en) begin
            led_n <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                led_n[i] <= ~(sel[i] & (pwm_cnt < duty));
        end
    end

endmodule

// File: tb/tb_breathe_seq.sv
// Scoreboard bench for breathe_seq: the driver computes the expected outputs
// from a cycle-count model and queues them; the monitor compares after each edge.
module tb_breathe_seq;

    localparam int NUM_CH = 3;
    localparam int PWM_BITS = 4;
    localparam int STEP_DIV = 2;
    localparam int BPC = 1;
    localparam int OFF_SLOT = 1;
    localparam int LMAX = (1 << PWM_BITS) - 1;
    localparam int BREATH_CYC = 2 * LMAX * STEP_DIV;
    localparam int NSLOT = NUM_CH + OFF_SLOT;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic [NUM_CH-1:0] led_n;
    logic [1:0]        active_ch;
    logic              breath_done;

    breathe_seq #(
        .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV),
        .BREATHS_PER_CH(BPC), .OFF_SLOT(OFF_SLOT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
        .led_n(led_n), .active_ch(active_ch), .breath_done(breath_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] led;
        int                ach;
        logic              bd;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // model state: enabled edges since reset, sampled mode, slot, breath count
    int m_edges = 0;
    int m_mq = 0;
    int m_slot = 0;
    int m_bcnt = 0;

    bit first_pending = 0;
    int rel_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tri_lvl(input int k);
        int p;
        p = k % (2 * LMAX);
        return (p <= LMAX) ? p : 2 * LMAX - p;
    endfunction

    // duty held in the DUT after m enabled edges: curve of level one edge earlier
    function automatic int duty_of(input int m);
        int lv;
        if (m < 1) return 0;
        lv = tri_lvl((m - 1) / STEP_DIV);
`ifdef BREATHE_SEQ_GAMMA_EN
        return (lv * lv) >> PWM_BITS;
`else
        return lv;
`endif
    endfunction

    task automatic model_reset();
        m_edges = 0; m_mq = 0; m_slot = 0; m_bcnt = 0;
    endtask

    // Drive inputs for the next edge, queue the expected response, advance.
    task automatic step(input logic e, input logic md);
        exp_t x;
        int   pwm, dty;
        en = e;
        mode = md;
        if (!e) begin
            x.led = '1;
            x.ach = m_slot;
            x.bd  = 1'b0;
        end else begin
            pwm = m_edges % (LMAX + 1);
            dty = duty_of(m_edges);
            for (int i = 0; i < NUM_CH; i++)
                x.led[i] = !(((m_mq == 1) || (m_slot == i)) && (pwm < dty));
            m_edges++;
            x.bd = (m_edges % BREATH_CYC) == 0;
            if (x.bd) begin
                m_mq = md;
                if (md) begin
                    m_slot = 0; m_bcnt = 0;
                end else begin
                    m_bcnt++;
                    if (m_bcnt == BPC) begin
                        m_bcnt = 0;
                        m_slot = (m_slot + 1) % NSLOT;
                    end
                end
            end
            x.ach = m_slot;
        end
        q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: compare each queued expectation just after its edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (first_pending && reset_n) begin
                rel_cyc++;
                if (breath_done) begin
                    first_pending = 0;
                    chk("first_breath_done_cycle", rel_cyc, BREATH_CYC);
                end
            end
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("led_n", led_n, x.led);
                chk("active_ch", active_ch, x.ach);
                chk("breath_done", breath_done, x.bd);
            end
        end
    end

    initial begin
        int freeze;
        logic md;

        // reset values while held
        repeat (4) @(negedge clk);
        chk("rst_led_n", led_n, 3'b111);
        chk("rst_active_ch", active_ch, 0);
        chk("rst_breath_done", breath_done, 0);

        // release into sequence mode, full rotation plus a bit
        model_reset();
        reset_n = 1'b1;
        first_pending = 1;
        rel_cyc = 0;
        for (int c = 0; c < 4 * BREATH_CYC + 20; c++) step(1'b1, 1'b0);

        // switch to unison mid-breath, run several breaths
        for (int c = 0; c < 3 * BREATH_CYC; c++) step(1'b1, 1'b1);

        // back to sequence, then a 37-cycle freeze mid-breath
        for (int c = 0; c < BREATH_CYC + 25; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 37; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 2 * BREATH_CYC; c++) step(1'b1, 1'b0);

        // randomized enable freezes and occasional mode flips
        freeze = 0;
        md = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            if ($urandom_range(0, 299) == 0) md = ~md;
            if (freeze == 0 && $urandom_range(0, 99) < 2)
                freeze = $urandom_range(1, 40);
            if (freeze > 0) begin
                freeze--;
                step(1'b0, md);
            end else begin
                step(1'b1, md);
            end
        end

        // restart, run into slot 2, then assert reset asynchronously
        reset_n = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 2 * BREATH_CYC + 17; c++) step(1'b1, 1'b0);
        chk("model_in_slot2", active_ch, 2);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_active_ch", active_ch, 0);
        chk("async_rst_led_n", led_n, 3'b111);
        chk("async_rst_breath_done", breath_done, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < BREATH_CYC + 30; c++) step(1'b1, 1'b0);

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("first_breath_done_seen", first_pending, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
